// File: rtl/sqrt_mant_iter.sv
// sqrt_mant_iter: restoring digit-by-digit mantissa square root.
// Ports: CLK/RST (sync, active-high), MANT_IN/VAL_IN in, MANT_OUT/VAL_OUT/BUSY out.
module sqrt_mant_iter #(
  parameter int mantlength = 24
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [mantlength-1:0] MANT_IN,
  input  logic                  VAL_IN,
  output logic [mantlength-1:0] MANT_OUT,
  output logic                  VAL_OUT,
  output logic                  BUSY
);

  localparam int N  = mantlength;
  localparam int RW = N + 2;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [N-1:0]  r_rad;
  logic [N-1:0]  r_root;
  logic [N-1:0]  r_out;
  logic [RW-1:0] r_rem;
  logic [RW-1:0] r_trial;
  logic          r_ge;
  logic          r_vo;
  logic          r_busy;
  logic [CW-1:0] r_cnt;

  logic [RW-1:0] w_rem_sh;
  logic [RW-1:0] w_trial;
  logic          w_co;
  logic [N-1:0]  w_root_nx;

  // Radicand is MANT_IN followed by N zero bits, so the
  // shift register only holds MANT_IN and back-fills zeros.
  // The remainder never exceeds 2*root, so the two bits
  // dropped by the cast are always zero.
  assign w_rem_sh = RW'({r_rem, r_rad[N-1:N-2]});

  // Trial subtraction: no borrow (CO=1) means trial >= 0.
  sqrt_mant_iter_addsub #(
    .W (RW)
  ) u_addsub (
    .A    (w_rem_sh),
    .B    ({r_root, 2'b01}),
    .ADD  (1'b0),
    .C_IN (1'b1),
    .S    (w_trial),
    .CO   (w_co)
  );

  assign w_root_nx = {r_root[N-2:0], r_ge};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rad   <= '0;
      r_root  <= '0;
      r_out   <= '0;
      r_rem   <= '0;
      r_trial <= '0;
      r_ge    <= 1'b0;
      r_vo    <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (VAL_IN) begin
            r_rad   <= MANT_IN;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          r_rem   <= w_rem_sh;
          r_rad   <= {r_rad[N-3:0], 2'b00};
          r_trial <= w_trial;
          r_ge    <= w_co;
          r_state <= S_UPD;
        end
        S_UPD: begin
          if (r_ge) begin
            r_rem <= r_trial;
          end
          r_root <= w_root_nx;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_out   <= w_root_nx;
            r_vo    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SUB;
          end
        end
        S_DONE: begin
          r_vo    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MANT_OUT = r_out;
  assign VAL_OUT  = r_vo;
  assign BUSY     = r_busy;

endmodule

// sqrt_mant_iter_addsub: combinational W-bit add/subtract.
// ADD=1: S=A+B+C_IN; ADD=0: S=A+~B+C_IN; CO is carry out.
module sqrt_mant_iter_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         ADD,
  input  logic         C_IN,
  output logic [W-1:0] S,
  output logic         CO
);

  logic [W-1:0] w_b;

  assign w_b = ADD ? B : ~B;
  assign {CO, S} = {1'b0, A} + {1'b0, w_b} + {{W{1'b0}}, C_IN};

endmodule

// File: tb/tb_sqrt_mant_iter.sv
// tb_sqrt_mant_iter: scoreboard bench for 24- and 53-bit roots.
// Directed vectors, random sweep, re-pulse, reset and back-to-back.
module tb_sqrt_mant_iter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        val24 = 1'b0;
  logic        val53 = 1'b0;
  logic [23:0] mant24 = '0;
  logic [52:0] mant53 = '0;
  logic [23:0] out24;
  logic [52:0] out53;
  logic        vo24, busy24, vo53, busy53;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] val;
    int          start;
  } exp_t;

  exp_t q24[$];
  exp_t q53[$];
  exp_t e24, e53;
  logic prev24 = 1'b0;
  logic prev53 = 1'b0;

  sqrt_mant_iter #(.mantlength(24)) u24 (
    .CLK      (CLK),
    .RST      (RST),
    .MANT_IN  (mant24),
    .VAL_IN   (val24),
    .MANT_OUT (out24),
    .VAL_OUT  (vo24),
    .BUSY     (busy24)
  );

  sqrt_mant_iter #(.mantlength(53)) u53 (
    .CLK      (CLK),
    .RST      (RST),
    .MANT_IN  (mant53),
    .VAL_IN   (val53),
    .MANT_OUT (out53),
    .VAL_OUT  (vo53),
    .BUSY     (busy53)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] isqrt(logic [127:0] x);
    logic [63:0]  r;
    logic [63:0]  c;
    logic [127:0] sq;
    r = '0;
    for (int b = 56; b >= 0; b--) begin
      c  = r | (64'd1 << b);
      sq = 128'(c) * 128'(c);
      if (sq <= x) r = c;
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (vo24) begin
      chk("vo24_width", 64'(prev24), 64'd0);
      chk("busy24_at_vo", 64'(busy24), 64'd1);
      if (q24.size() == 0) begin
        chk("vo24_unexpected", 64'(vo24), 64'd0);
      end else begin
        e24 = q24.pop_front();
        chk("out24", 64'(out24), e24.val);
        chk("lat24", 64'(cyc - e24.start), 64'd48);
      end
    end
    prev24 <= vo24;
  end

  always @(negedge CLK) begin
    if (vo53) begin
      chk("vo53_width", 64'(prev53), 64'd0);
      chk("busy53_at_vo", 64'(busy53), 64'd1);
      if (q53.size() == 0) begin
        chk("vo53_unexpected", 64'(vo53), 64'd0);
      end else begin
        e53 = q53.pop_front();
        chk("out53", 64'(out53), e53.val);
        chk("lat53", 64'(cyc - e53.start), 64'd106);
      end
    end
    prev53 <= vo53;
  end

  task automatic go24(input logic [23:0] m, input bit push,
                      input logic [23:0] e);
    @(posedge CLK); #1;
    val24  = 1'b1;
    mant24 = m;
    @(posedge CLK); #1;
    val24  = 1'b0;
    mant24 = ~m;
    if (push) q24.push_back('{64'(e), cyc});
  endtask

  task automatic go53(input logic [52:0] m, input bit push,
                      input logic [52:0] e);
    @(posedge CLK); #1;
    val53  = 1'b1;
    mant53 = m;
    @(posedge CLK); #1;
    val53  = 1'b0;
    mant53 = ~m;
    if (push) q53.push_back('{64'(e), cyc});
  endtask

  task automatic wait24();
    for (int i = 0; i < 400 && q24.size() != 0; i++)
      @(posedge CLK);
    #1;
    chk("done24_timeout", 64'(q24.size()), 64'd0);
  endtask

  task automatic wait53();
    for (int i = 0; i < 400 && q53.size() != 0; i++)
      @(posedge CLK);
    #1;
    chk("done53_timeout", 64'(q53.size()), 64'd0);
  endtask

  logic [23:0] dm24 [5] = '{24'h400000, 24'h800000, 24'h900000,
                            24'hFFFFFF, 24'h000000};
  logic [23:0] de24 [5] = '{24'h800000, 24'hB504F3, 24'hC00000,
                            24'hFFFFFF, 24'h000000};

  initial begin
    logic [23:0] m24;
    logic [52:0] m53;
    logic [63:0] rr;
    int          e0;

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_out24", 64'(out24), 64'd0);
    chk("rst_vo24", 64'(vo24), 64'd0);
    chk("rst_busy24", 64'(busy24), 64'd0);
    chk("rst_out53", 64'(out53), 64'd0);
    chk("rst_busy53", 64'(busy53), 64'd0);

    for (int i = 0; i < 5; i++) begin
      go24(dm24[i], 1'b1, de24[i]);
      chk("busy24_run", 64'(busy24), 64'd1);
      wait24();
    end

    // Re-pulse during a run is ignored.
    go24(24'h400000, 1'b1, 24'h800000);
    repeat (9) @(posedge CLK);
    #1;
    val24  = 1'b1;
    mant24 = 24'h800000;
    @(posedge CLK); #1;
    val24 = 1'b0;
    wait24();

    // Mid-operation reset aborts silently.
    go24(24'h900000, 1'b0, 24'h0);
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_out24", 64'(out24), 64'd0);
    chk("abort_vo24", 64'(vo24), 64'd0);
    chk("abort_busy24", 64'(busy24), 64'd0);
    repeat (120) @(posedge CLK);

    // Reset together with a start does not start.
    #1;
    RST    = 1'b1;
    val24  = 1'b1;
    mant24 = 24'h400000;
    @(posedge CLK); #1;
    RST   = 1'b0;
    val24 = 1'b0;
    chk("rststart_busy24", 64'(busy24), 64'd0);
    @(posedge CLK); #1;
    chk("rststart_busy24_b", 64'(busy24), 64'd0);

    for (int i = 0; i < 8; i++) begin
      m24 = 24'($urandom_range(32'hFFFFFF, 32'h400000));
      go24(m24, 1'b1, 24'(isqrt(128'(m24) << 24)));
      wait24();
    end

    // VAL_IN held high: starts every 2N+2 edges.
    @(posedge CLK); #1;
    e0     = cyc + 1;
    val24  = 1'b1;
    mant24 = 24'h900000;
    for (int k = 0; k < 3; k++)
      q24.push_back('{64'h0000_0000_00C0_0000, e0 + k * 50});
    repeat (101) @(posedge CLK);
    #1;
    val24 = 1'b0;
    wait24();

    go53(53'd1 << 51, 1'b1, 53'd1 << 52);
    wait53();
    go53(53'd1 << 52, 1'b1, 53'h16A09E667F3BCC);
    wait53();
    go53(53'h0, 1'b1, 53'h0);
    wait53();

    for (int i = 0; i < 6; i++) begin
      rr  = {$urandom, $urandom};
      m53 = rr[52:0];
      if (!m53[52] && !m53[51]) m53[51] = 1'b1;
      go53(m53, 1'b1, 53'(isqrt(128'(m53) << 53)));
      wait53();
    end

    repeat (4) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
